// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: owns every hold, flush and bubble.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned REG_ADDR_W     = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IMEM_BUSYWAIT,
    input  logic                  DMEM_BUSYWAIT,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_IS_MULDIV,
    input  logic                  BRANCH_TAKEN,
    output logic                  PC_HOLD,
    output logic                  IF_ID_HOLD,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_HOLD,
    output logic                  ID_EX_BUBBLE,
    output logic                  EX_HOLD,
    output logic                  MULDIV_BUSY,
    output logic [31:0]           STALL_CYCLES,
    output logic [31:0]           FLUSH_COUNT
);

    localparam logic ST_RUN     = 1'b0;
    localparam logic ST_MD_WAIT = 1'b1;

    // Single-cycle M ops never enter MD_WAIT; the first hold cycle is spent in RUN.
    localparam bit        MD_MULTI = (MULDIV_LATENCY > 1);
    localparam logic [5:0] CNT_LOAD = MD_MULTI ? 6'(MULDIV_LATENCY - 2) : 6'd0;

    logic       state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_hold_c, id_ex_bubble_c, ex_hold_c;
    logic branch_flush_c;
    logic load_use;

    assign load_use = EX_MEM_READ && (EX_RD != '0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_hold_c   = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_hold_c      = 1'b0;
        branch_flush_c = 1'b0;

        if (DMEM_BUSYWAIT) begin
            pc_hold_c    = 1'b1;
            if_id_hold_c = 1'b1;
            id_ex_hold_c = 1'b1;
            ex_hold_c    = 1'b1;
        end else if (state_q == ST_MD_WAIT) begin
            if (cnt_q != 6'd0) begin
                pc_hold_c    = 1'b1;
                if_id_hold_c = 1'b1;
                id_ex_hold_c = 1'b1;
                ex_hold_c    = 1'b1;
                cnt_d        = cnt_q - 6'd1;
            end else begin
                // Release cycle: the next op (even another MUL/DIV) enters EX on this edge.
                state_d = ST_RUN;
            end
        end else if (BRANCH_TAKEN) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            branch_flush_c = 1'b1;
        end else if (EX_IS_MULDIV && MD_MULTI) begin
            pc_hold_c    = 1'b1;
            if_id_hold_c = 1'b1;
            id_ex_hold_c = 1'b1;
            ex_hold_c    = 1'b1;
            cnt_d        = CNT_LOAD;
            state_d      = ST_MD_WAIT;
        end else if (load_use) begin
            pc_hold_c      = 1'b1;
            if_id_hold_c   = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (IMEM_BUSYWAIT) begin
            pc_hold_c     = 1'b1;
            if_id_flush_c = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        PC_HOLD      = 1'b0;
        IF_ID_HOLD   = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_HOLD   = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        EX_HOLD      = 1'b0;
        MULDIV_BUSY  = 1'b0;
        if (!RESET) begin
            PC_HOLD      = pc_hold_c;
            IF_ID_HOLD   = if_id_hold_c;
            IF_ID_FLUSH  = if_id_flush_c;
            ID_EX_HOLD   = id_ex_hold_c;
            ID_EX_BUBBLE = id_ex_bubble_c;
            EX_HOLD      = ex_hold_c;
            MULDIV_BUSY  = (state_q == ST_MD_WAIT);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (pc_hold_c && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            // Only branch flushes count; IMEM-busy flushes are fetch bubbles, not redirects.
            if (branch_flush_c && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign STALL_CYCLES = RESET ? 32'd0 : stall_q;
    assign FLUSH_COUNT  = RESET ? 32'd0 : flush_q;
`else
    assign STALL_CYCLES = 32'd0;
    assign FLUSH_COUNT  = 32'd0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (!(IF_ID_HOLD && IF_ID_FLUSH))
                else $error("IF/ID hold and flush asserted together");
            assert (!(ID_EX_HOLD && ID_EX_BUBBLE))
                else $error("ID/EX hold and bubble asserted together");
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32IM pipeline. It drives hold/flush/bubble controls to the PC, IF/ID and ID/EX registers and the EX stage. Sources are load-use hazards, taken branches in EX, multi-cycle MUL/DIV occupancy, and instruction and data memory busywait. It is the single owner of all pipeline freeze decisions.

Parameters:
MULDIV_LATENCY, 4, total cycles an M-extension op occupies EX (legal range 1..64)
REG_ADDR_W, 5, register-index width

Ports:
CLK  in  1  clock, posedge
RESET  in  1  synchronous, active-high
IMEM_BUSYWAIT  in  1  instruction memory not ready
DMEM_BUSYWAIT  in  1  data memory not ready
ID_RS1  in  REG_ADDR_W  rs1 of instruction in ID
ID_RS2  in  REG_ADDR_W  rs2 of instruction in ID
ID_USES_RS1  in  1  ID instruction reads rs1
ID_USES_RS2  in  1  ID instruction reads rs2
EX_RD  in  REG_ADDR_W  rd of instruction in EX
EX_MEM_READ  in  1  EX instruction is a load
EX_IS_MULDIV  in  1  EX instruction is MUL/DIV/REM
BRANCH_TAKEN  in  1  EX resolved a taken branch/jump
PC_HOLD  out  1  PC keeps its value
IF_ID_HOLD  out  1  IF/ID keeps its contents
IF_ID_FLUSH  out  1  IF/ID loads NOP (0x00000013)
ID_EX_HOLD  out  1  ID/EX keeps its contents
ID_EX_BUBBLE  out  1  ID/EX loads NOP controls
EX_HOLD  out  1  EX/MEM keeps its contents
MULDIV_BUSY  out  1  state == MD_WAIT
STALL_CYCLES  out  32  stall counter (optional feature)
FLUSH_COUNT  out  32  flush counter (optional feature)

Behaviour:
- State register: RUN, MD_WAIT. Down-counter cnt is 6 bits wide.
- Outputs are combinational from state, cnt and inputs. State and cnt update on posedge CLK.
- Reset: on a posedge with RESET=1, state goes to RUN and cnt to 0. While RESET=1, all outputs are forced to 0. A reset during MD_WAIT aborts the wait and returns to RUN.
- Output rules are applied in priority order; the first matching rule decides:
- 1. DMEM_BUSYWAIT=1: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD and EX_HOLD are all 1. FLUSH and BUBBLE are 0. State and cnt are frozen.
- 2. MD_WAIT with cnt != 0: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD and EX_HOLD are 1. cnt decrements.
- 3. MD_WAIT with cnt == 0: all holds are 0. Next state is RUN. EX_IS_MULDIV is ignored this cycle.
- 4. RUN with BRANCH_TAKEN: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_HOLD=0 (PC takes the target). This masks load-use and IMEM busy.
- 5. RUN with EX_IS_MULDIV and MULDIV_LATENCY > 1: same holds as rule 2. cnt loads MULDIV_LATENCY-2. Next state is MD_WAIT.
- 6. RUN with a load-use hazard: PC_HOLD=1, IF_ID_HOLD=1, ID_EX_BUBBLE=1. The hazard condition is EX_MEM_READ && EX_RD != 0 && ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD)). This produces exactly one bubble; no state is kept.
- 7. RUN with IMEM_BUSYWAIT: PC_HOLD=1, IF_ID_FLUSH=1. ID and later stages keep draining.
- 8. Otherwise all outputs are 0.
- Net effect of a MUL/DIV: it occupies EX for exactly MULDIV_LATENCY cycles (MULDIV_LATENCY-1 hold cycles). DMEM busy cycles extend this 1:1.
- Back-to-back MUL/DIV: the second op enters EX on the release edge and restarts the sequence from RUN.
- HOLD and FLUSH are never both 1 for the same register. BUBBLE and HOLD are never both 1 for ID/EX.

Optional Feature:
HAZARD_STATS_EN
- Defined: STALL_CYCLES increments on every non-reset cycle with PC_HOLD=1. FLUSH_COUNT increments on every cycle with IF_ID_FLUSH=1 caused by rule 4 only. Both clear on RESET and saturate at 0xFFFFFFFF.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 -> exactly one cycle of PC_HOLD=IF_ID_HOLD=ID_EX_BUBBLE=1, then all outputs 0.
- Load to x0: EX_RD=0, ID_RS1=0 -> no stall.
- MUL with MULDIV_LATENCY=4: EX_IS_MULDIV held for 4 cycles -> holds on cycles 1-3, released on cycle 4, MULDIV_BUSY on cycles 2-4. Repeat with MULDIV_LATENCY=1 -> no holds.
- DMEM_BUSYWAIT pulsed 2 cycles during MD_WAIT with cnt=1 -> all holds for 2 cycles, cnt stays 1, release is delayed by 2 cycles.
- BRANCH_TAKEN together with a load-use hazard and IMEM_BUSYWAIT -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_HOLD=0. With HAZARD_STATS_EN, FLUSH_COUNT increments by 1.
- RESET asserted in MD_WAIT with cnt=2 -> outputs 0 during reset, state RUN after the edge, no residual holds.
